// File: rtl/instr_encode_rv_if.sv
// -----------------------------------------------------------------------------
// instr_encode_rv_if
//   Bundles the request channel (field-level instruction description) and the
//   response channel (packed instruction word plus address) of the RV32I
//   instruction encoder.
//
//   Request channel  : iwValid/owReady handshake carrying iwFormat, iwOpCode,
//                      iwFunct3, iwFunct7, iwRd, iwRs1, iwRs2, iwImmediate.
//   Response channel : orValid/iwReady handshake carrying orInstr, orAddr,
//                      orError; orCount counts completed response handshakes.
//
//   modport slave  : the encoder itself.
//   modport master : the agent that issues requests and consumes words.
// -----------------------------------------------------------------------------
interface instr_encode_rv_if;
    logic        iwValid;
    logic        owReady;
    logic [2:0]  iwFormat;
    logic [6:0]  iwOpCode;
    logic [2:0]  iwFunct3;
    logic [6:0]  iwFunct7;
    logic [4:0]  iwRd;
    logic [4:0]  iwRs1;
    logic [4:0]  iwRs2;
    logic [31:0] iwImmediate;

    logic        orValid;
    logic        iwReady;
    logic [31:0] orInstr;
    logic [31:0] orAddr;
    logic        orError;
    logic [15:0] orCount;

    modport slave (
        input  iwValid, iwFormat, iwOpCode, iwFunct3, iwFunct7,
               iwRd, iwRs1, iwRs2, iwImmediate, iwReady,
        output owReady, orValid, orInstr, orAddr, orError, orCount
    );

    modport master (
        output iwValid, iwFormat, iwOpCode, iwFunct3, iwFunct7,
               iwRd, iwRs1, iwRs2, iwImmediate, iwReady,
        input  owReady, orValid, orInstr, orAddr, orError, orCount
    );
endinterface

// File: rtl/instr_encode_rv.sv
// -----------------------------------------------------------------------------
// instr_encode_rv
//   RV32I instruction encoder. Accepts a field-level instruction description,
//   range-checks the immediate for the selected format, packs the 32-bit
//   instruction word and emits it together with its instruction-memory
//   address. Illegal requests are still accepted and consume an address slot;
//   they are emitted as an all-zero word with orError set.
//
//   Ports:
//     iwClk    in   clock
//     iwRst    in   synchronous reset, active-high (dominates iwFlush)
//     iwFlush  in   synchronous drop of all pending words, address counter
//                   back to BASE_ADDR, orCount untouched
//     bus      slave modport of instr_encode_rv_if (request + response)
//
//   Buffering: one output register plus a one-entry skid buffer, so at most
//   two words are held under backpressure and ordering is preserved.
// -----------------------------------------------------------------------------
module instr_encode_rv #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              iwClk,
    input  logic              iwRst,
    input  logic              iwFlush,
    instr_encode_rv_if.slave  bus
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [31:0] addrCnt;

    logic        outValid;
    logic [31:0] outInstr;
    logic [31:0] outAddr;
    logic        outError;

    logic        skidValid;
    logic [31:0] skidInstr;
    logic [31:0] skidAddr;
    logic        skidError;

    logic [15:0] hsCount;

    logic [31:0] encWord;
    logic        encLegal;
    logic [31:0] newInstr;
    logic        newError;

    logic        accept;
    logic        drain;
    logic        outFree;

    // ------------------------------------------------------------------
    // Field packing and legality. The immediate is a signed byte offset;
    // a value fits an N-bit signed field when every bit above the field's
    // sign bit equals that sign bit.
    // ------------------------------------------------------------------
    always_comb begin
        encWord  = 32'h0;
        encLegal = 1'b0;
        case (bus.iwFormat)
            FMT_R: begin
                encWord  = {bus.iwFunct7, bus.iwRs2, bus.iwRs1, bus.iwFunct3,
                            bus.iwRd, bus.iwOpCode};
                encLegal = 1'b1;
            end
            FMT_I: begin
                encWord  = {bus.iwImmediate[11:0], bus.iwRs1, bus.iwFunct3,
                            bus.iwRd, bus.iwOpCode};
                encLegal = (bus.iwImmediate[31:11] == {21{bus.iwImmediate[11]}});
            end
            FMT_S: begin
                encWord  = {bus.iwImmediate[11:5], bus.iwRs2, bus.iwRs1,
                            bus.iwFunct3, bus.iwImmediate[4:0], bus.iwOpCode};
                encLegal = (bus.iwImmediate[31:11] == {21{bus.iwImmediate[11]}});
            end
            FMT_B: begin
                encWord  = {bus.iwImmediate[12], bus.iwImmediate[10:5],
                            bus.iwRs2, bus.iwRs1, bus.iwFunct3,
                            bus.iwImmediate[4:1], bus.iwImmediate[11],
                            bus.iwOpCode};
                encLegal = (bus.iwImmediate[31:12] == {20{bus.iwImmediate[12]}})
                           && !bus.iwImmediate[0];
            end
            FMT_U: begin
                encWord  = {bus.iwImmediate[31:12], bus.iwRd, bus.iwOpCode};
                encLegal = (bus.iwImmediate[11:0] == 12'h000);
            end
            FMT_J: begin
                encWord  = {bus.iwImmediate[20], bus.iwImmediate[10:1],
                            bus.iwImmediate[11], bus.iwImmediate[19:12],
                            bus.iwRd, bus.iwOpCode};
                encLegal = (bus.iwImmediate[31:20] == {12{bus.iwImmediate[20]}})
                           && !bus.iwImmediate[0];
            end
            default: begin
                encWord  = 32'h0;
                encLegal = 1'b0;
            end
        endcase
    end

    assign newInstr = encLegal ? encWord : 32'h0;
    assign newError = !encLegal;

    // ------------------------------------------------------------------
    // Handshakes. The skid entry is only ever filled while the output
    // register is held, so a full skid is the only reason to stall.
    // ------------------------------------------------------------------
    assign bus.owReady = !skidValid && !iwRst && !iwFlush;
    assign accept      = bus.iwValid && bus.owReady;
    assign drain       = outValid && bus.iwReady;
    assign outFree     = !outValid || drain;

    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            addrCnt   <= BASE_ADDR;
            outValid  <= 1'b0;
            outInstr  <= 32'h0;
            outAddr   <= BASE_ADDR;
            outError  <= 1'b0;
            skidValid <= 1'b0;
            skidInstr <= 32'h0;
            skidAddr  <= BASE_ADDR;
            skidError <= 1'b0;
            hsCount   <= 16'h0;
        end else if (iwFlush) begin
            addrCnt   <= BASE_ADDR;
            outValid  <= 1'b0;
            skidValid <= 1'b0;
        end else begin
            if (drain) begin
                hsCount <= hsCount + 16'd1;
            end

            if (accept) begin
                addrCnt <= addrCnt + 32'd4;
            end

            if (outFree) begin
                // Skid is older than any new request, so it drains first.
                // accept cannot be true while skidValid is set.
                if (skidValid) begin
                    outValid  <= 1'b1;
                    outInstr  <= skidInstr;
                    outAddr   <= skidAddr;
                    outError  <= skidError;
                    skidValid <= 1'b0;
                end else if (accept) begin
                    outValid  <= 1'b1;
                    outInstr  <= newInstr;
                    outAddr   <= addrCnt;
                    outError  <= newError;
                end else begin
                    outValid  <= 1'b0;
                end
            end else if (accept) begin
                skidValid <= 1'b1;
                skidInstr <= newInstr;
                skidAddr  <= addrCnt;
                skidError <= newError;
            end
        end
    end

    assign bus.orValid = outValid;
    assign bus.orInstr = outInstr;
    assign bus.orAddr  = outAddr;
    assign bus.orError = outError;
    assign bus.orCount = hsCount;

endmodule

// File: tb/tb_instr_encode_rv.sv
module tb_instr_encode_rv;

    logic clk;
    logic rst;
    logic flush;

    instr_encode_rv_if bus ();

    instr_encode_rv #(.BASE_ADDR(32'h0000_0000)) dut (
        .iwClk   (clk),
        .iwRst   (rst),
        .iwFlush (flush),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] qInstr[$];
    logic [31:0] qAddr[$];
    logic        qErr[$];
    logic [31:0] expAddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever an output handshake is about to
    // complete on the next rising edge.
    always @(negedge clk) begin
        if (bus.orValid && bus.iwReady && !rst && !flush) begin
            if (qInstr.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL unexpected_word: got %h at addr %h, none expected", bus.orInstr, bus.orAddr);
            end else begin
                chk("instr", bus.orInstr, qInstr.pop_front());
                chk("addr",  bus.orAddr,  qAddr.pop_front());
                chk("error", {31'h0, bus.orError}, {31'h0, qErr.pop_front()});
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] expI, input logic expE);
        bit done = 0;
        bus.iwFormat = fmt; bus.iwOpCode = op; bus.iwFunct3 = f3; bus.iwFunct7 = f7;
        bus.iwRd = rd; bus.iwRs1 = rs1; bus.iwRs2 = rs2; bus.iwImmediate = imm;
        bus.iwValid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.owReady) begin
                qInstr.push_back(expI);
                qAddr.push_back(expAddr);
                qErr.push_back(expE);
                expAddr = expAddr + 32'd4;
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            nChecks++;
            nFails++;
            $display("FAIL accept_timeout: owReady stayed 0, required 1");
        end
        bus.iwValid = 1'b0;
    endtask

    task automatic drainWait();
        int n = 0;
        while (qInstr.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (qInstr.size() != 0) begin
            nChecks++;
            nFails++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", qInstr.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1;
        qInstr.delete(); qAddr.delete(); qErr.delete();
        expAddr = 32'h0;
        @(negedge clk);
        chk("owReady_in_reset", {31'h0, bus.owReady}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_orValid", {31'h0, bus.orValid}, 32'h0);
        chk("rst_orInstr", bus.orInstr, 32'h0);
        chk("rst_orAddr",  bus.orAddr,  32'h0);
        chk("rst_orError", {31'h0, bus.orError}, 32'h0);
        chk("rst_orCount", {16'h0, bus.orCount}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("owReady_after_reset", {31'h0, bus.owReady}, 32'h1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; expAddr = 32'h0;
        bus.iwValid = 1'b0; bus.iwReady = 1'b1;
        bus.iwFormat = 3'd0; bus.iwOpCode = 7'h0; bus.iwFunct3 = 3'd0; bus.iwFunct7 = 7'h0;
        bus.iwRd = 5'd0; bus.iwRs1 = 5'd0; bus.iwRs2 = 5'd0; bus.iwImmediate = 32'h0;
        repeat (2) @(posedge clk);
        doReset();

        // addi x1,x0,5 then orCount after its handshake
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
        drainWait();
        chk("count_after_addi", {16'h0, bus.orCount}, 32'd1);

        // legal words of every format, back to back
        send(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_A423, 1'b0);
        send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
        send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h0010_00EF, 1'b0);
        send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0,         32'h0020_81B3, 1'b0);
        send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'h0,         32'h4020_81B3, 1'b0);
        send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        // range boundaries that are still legal
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2047,      32'h7FF0_0093, 1'b0);
        send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4094,      32'h7E00_0FE3, 1'b0);
        send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000, 32'h8000_006F, 1'b0);
        // illegal requests still take an address slot
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h0, 1'b1);
        send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3,         32'h0, 1'b1);
        send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h0000_1001, 32'h0, 1'b1);
        send(3'd6, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0,         32'h0, 1'b1);
        send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3,         32'h0, 1'b1);
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1,         32'h0010_0093, 1'b0);
        drainWait();
        chk("count_after_batch", {16'h0, bus.orCount}, 32'd17);

        // backpressure: four requests, downstream stalled three cycles
        doReset();
        bus.iwReady = 1'b0;
        fork
            begin
                send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
                send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b0);
                send(3'd1, 7'h13, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'd3, 32'h0030_0193, 1'b0);
                send(3'd1, 7'h13, 3'd0, 7'h00, 5'd4, 5'd0, 5'd0, 32'd4, 32'h0040_0213, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("owReady_skid_full", {31'h0, bus.owReady}, 32'h0);
                chk("held_orAddr", bus.orAddr, 32'h0);
                @(posedge clk); #1;
                bus.iwReady = 1'b1;
            end
        join
        drainWait();
        chk("count_after_backpressure", {16'h0, bus.orCount}, 32'd4);

        // flush with two words pending and a request on the bus
        bus.iwReady = 1'b0;
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd9, 32'h0090_0093, 1'b0);
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd9, 32'h0090_0113, 1'b0);
        bus.iwValid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("owReady_in_flush", {31'h0, bus.owReady}, 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.iwValid = 1'b0;
        qInstr.delete(); qAddr.delete(); qErr.delete();
        expAddr = 32'h0;
        @(negedge clk);
        chk("flush_orValid", {31'h0, bus.orValid}, 32'h0);
        chk("flush_orCount", {16'h0, bus.orCount}, 32'd4);
        @(posedge clk); #1;
        bus.iwReady = 1'b1;
        send(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0);
        drainWait();

        // reset mid-stream with output held
        bus.iwReady = 1'b0;
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd5, 32'h0050_0113, 1'b0);
        doReset();
        bus.iwReady = 1'b1;
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
        drainWait();
        chk("count_after_reset_stream", {16'h0, bus.orCount}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
